frame_mem_arbiter: RTL

FRAME_MEM_ARBITER -- requirements
Module: frame_mem_arbiter

---
 rtl/frame_mem_arbiter_pkg.sv | 28 ++
 rtl/frame_mem_arbiter_cap_wr_fifo.sv | 52 +++++
 rtl/frame_mem_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/frame_mem_arbiter_pkg.sv
// Shared ZBT widths, the arbiter state encoding and the capture FIFO entry layout
// for frame_mem_arbiter.
package frame_mem_arbiter_pkg;

  localparam int ZBT_AW         = 19;
  localparam int ZBT_DW         = 36;
  localparam int RD_AW          = 18;
  localparam int RD_LAT_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ZBT_AW-1:0] addr;
    logic [ZBT_DW-1:0] data;
  } wr_entry_t;

  // Two pixels share one word, so the word address drops x[0].
  function automatic logic [ZBT_AW-1:0] cap_addr(input logic       bank,
                                                 input logic [8:0] y,
                                                 input logic [9:0] x);
    return {bank, y, x[9:1]};
  endfunction

endpackage

// File: rtl/frame_mem_arbiter_cap_wr_fifo.sv
// cap_wr_fifo: synchronous capture write FIFO with push, pop, full, empty and count.
// A push to a full FIFO is accepted only when a pop happens in the same cycle.
module cap_wr_fifo
  import frame_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wr_entry_t                din,
  input  logic                     pop,
  output wr_entry_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wr_entry_t       store [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = store[rd_ptr];

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is left unreset; count/pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= din;
  end

endmodule

// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter: shares one ZBT port between capture writes and display reads.
// Optional DOUBLE_BUFFER_EN enables frame-based bank switching between write and read.
module frame_mem_arbiter
  import frame_mem_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = RD_LAT_DEFAULT,
  parameter int WR_URGENT  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [35:0]       ntsc_pixels,
  input  logic              ntsc_flag,
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  input  logic              frame_flag,
  input  logic              rd_req,
  input  logic [RD_AW-1:0]  rd_addr,
  output logic              rd_ack,
  output logic [ZBT_DW-1:0] rd_data,
  output logic              rd_valid,
  output logic [ZBT_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [ZBT_DW-1:0] mem_wdata,
  input  logic [ZBT_DW-1:0] mem_rdata,
  output logic              overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            bank_w;
  logic            bank_r;
  arb_state_e      state;
  arb_state_e      nxt;
  wr_entry_t       push_entry;
  wr_entry_t       head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            wr_pop;
  logic            rd_issued;
  logic            data_due;
  logic [RD_LAT-1:0] vld_sr;
  logic            unused_bits;

`ifdef DOUBLE_BUFFER_EN
  always_ff @(posedge clk) begin
    if (reset)           bank_w <= 1'b0;
    else if (frame_flag) bank_w <= ~bank_w;
  end
  assign bank_r      = ~bank_w;
  assign unused_bits = x[0];
`else
  assign bank_w      = 1'b0;
  assign bank_r      = 1'b0;
  assign unused_bits = ^{x[0], frame_flag};
`endif

  assign push_entry = '{addr: cap_addr(bank_w, y, x), data: ntsc_pixels};

  cap_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ntsc_flag),
    .din   (push_entry),
    .pop   (wr_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A backlog at WR_URGENT pre-empts reads so capture cannot overflow under steady load.
  // NOTE: the default assignment first keeps always_comb free of inferred latches.
  always_comb begin
    nxt = IDLE;
    if (32'(fifo_count) >= WR_URGENT) nxt = WRITE;
    else if (rd_req)                  nxt = READ;
    else if (!fifo_empty)             nxt = WRITE;
  end

  assign wr_pop = (nxt == WRITE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_ack    <= 1'b0;
    end else begin
      state  <= nxt;
      mem_we <= 1'b0;
      rd_ack <= 1'b0;
      unique case (nxt)
        READ: begin
          mem_addr <= {bank_r, rd_addr};
          rd_ack   <= 1'b1;
        end
        WRITE: begin
          mem_addr  <= head.addr;
          mem_wdata <= head.data;
          mem_we    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                   overflow <= 1'b0;
    else if (ntsc_flag && fifo_full && !wr_pop)  overflow <= 1'b1;
  end

  // The command launched with rd_ack returns on the RD_LAT-th edge after it.
  assign rd_issued = (state == READ);

  if (RD_LAT == 1) begin : g_lat1
    assign data_due = rd_issued;
  end else begin : g_latn
    assign data_due = vld_sr[RD_LAT-2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_sr  <= '0;
      rd_data <= '0;
    end else begin
      vld_sr[0] <= rd_issued;
      for (int i = 1; i < RD_LAT; i++) vld_sr[i] <= vld_sr[i-1];
      if (data_due) rd_data <= mem_rdata;
    end
  end

  assign rd_valid = vld_sr[RD_LAT-1];

endmodule
